// File: rtl/interrupt_monitor_pkg.sv
// Shared definitions for the multi-channel interrupt monitor: the FSM state
// encoding, the edge-select codes and the edge-qualification helper.
package interrupt_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE               = 2'd0,
    ST_LATCHINITSTATE     = 2'd1,
    ST_RESETTRANSITIONREG = 2'd2,
    ST_ARMED              = 2'd3
  } mon_state_e;

  localparam logic [1:0] EDGE_FALL = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_RSVD = 2'b11;  // decoded as falling

  // Selects which synchronized edge qualifies under the latched edge mode.
  function automatic logic edge_hit(input logic [1:0] sel, input logic rise, input logic fall);
    logic hit;
    case (sel)
      EDGE_RISE: hit = rise;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = fall;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/interrupt_sync_edge.sv
// Per-line synchronizer with history flop and registered rise/fall pulses.
// All synchronizer and history flops reset to 1 (line idle high).
module interrupt_sync_edge #(
  parameter int SYNC_STAGES = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic line_bar,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic                   rise_r;
  logic                   fall_r;

  // Shift the raw line through the synchronizer and register edge pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_r <= {SYNC_STAGES{1'b1}};
      hist_r <= 1'b1;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], line_bar};
      hist_r <= sync_r[SYNC_STAGES-1];
      rise_r <= ~hist_r & sync_r[SYNC_STAGES-1];
      fall_r <= hist_r & ~sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/interrupt_monitor_multi.sv
// Multi-channel interrupt edge monitor: arm sequence FSM, sticky per-channel
// edge flags and optional saturating transition counters.
// Optional feature macro: INTERRUPT_MONITOR_COUNT_EN (enables counters).
module interrupt_monitor_multi
  import interrupt_monitor_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    STOP,
  input  logic [1:0]              EDGE_SEL,
  input  logic [N_CH-1:0]         CH_MASK,
  input  logic [N_CH-1:0]         INTERRUPT_BAR,
  output logic                    BUSY,
  output logic                    ARMED,
  output logic [N_CH-1:0]         INTERRUPT_INIT_STATE,
  output logic [N_CH-1:0]         INTERRUPT_TRANSITION,
  output logic                    ANY_TRANSITION,
  output logic [N_CH*CNT_W-1:0]   TRANSITION_COUNT
);

  mon_state_e      state_r;
  mon_state_e      state_s;
  logic            busy_r;
  logic            armed_r;
  logic [1:0]      edge_sel_r;
  logic [N_CH-1:0] mask_r;
  logic [N_CH-1:0] init_r;
  logic [N_CH-1:0] trans_r;
  logic            any_r;
  logic [N_CH-1:0] level_s;
  logic [N_CH-1:0] rise_s;
  logic [N_CH-1:0] fall_s;
  logic [N_CH-1:0] hit_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    interrupt_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .CLK      (CLK),
      .RST      (RST),
      .line_bar (INTERRUPT_BAR[g]),
      .level    (level_s[g]),
      .rise     (rise_s[g]),
      .fall     (fall_s[g])
    );
    assign hit_s[g] = mask_r[g] & edge_hit(edge_sel_r, rise_s[g], fall_s[g]);
  end

  // Next-state logic; START/STOP only matter in IDLE and ARMED.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START) state_s = ST_LATCHINITSTATE;
        else       state_s = ST_IDLE;
      end
      ST_LATCHINITSTATE:     state_s = ST_RESETTRANSITIONREG;
      ST_RESETTRANSITIONREG: state_s = ST_ARMED;
      ST_ARMED: begin
        if (START)     state_s = ST_LATCHINITSTATE;
        else if (STOP) state_s = ST_IDLE;
        else           state_s = ST_ARMED;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register with BUSY/ARMED registered from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_LATCHINITSTATE) || (state_s == ST_RESETTRANSITIONREG);
      armed_r <= (state_s == ST_ARMED);
    end
  end

  // Configuration latch, initial-level capture and sticky edge flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_sel_r <= EDGE_FALL;
      mask_r     <= {N_CH{1'b0}};
      init_r     <= {N_CH{1'b0}};
      trans_r    <= {N_CH{1'b0}};
      any_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_LATCHINITSTATE: begin
          edge_sel_r <= EDGE_SEL;
          mask_r     <= CH_MASK;
          init_r     <= level_s;
        end
        ST_RESETTRANSITIONREG: begin
          trans_r <= {N_CH{1'b0}};
          any_r   <= 1'b0;
        end
        ST_ARMED: begin
          trans_r <= trans_r | hit_s;
          any_r   <= |(trans_r | hit_s);
        end
        default: begin
          trans_r <= trans_r;
          any_r   <= any_r;
        end
      endcase
    end
  end

`ifdef INTERRUPT_MONITOR_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_r [N_CH];

  // Saturating per-channel counters of qualified edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_CH; i++) cnt_r[i] <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_RESETTRANSITIONREG: begin
          for (int i = 0; i < N_CH; i++) cnt_r[i] <= {CNT_W{1'b0}};
        end
        ST_ARMED: begin
          for (int i = 0; i < N_CH; i++) begin
            if (hit_s[i] && (cnt_r[i] != CNT_MAX)) cnt_r[i] <= cnt_r[i] + CNT_ONE;
            else                                   cnt_r[i] <= cnt_r[i];
          end
        end
        default: begin
          for (int i = 0; i < N_CH; i++) cnt_r[i] <= cnt_r[i];
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign TRANSITION_COUNT[g*CNT_W +: CNT_W] = cnt_r[g];
  end
`else
  assign TRANSITION_COUNT = {(N_CH*CNT_W){1'b0}};
`endif

  assign BUSY                 = busy_r;
  assign ARMED                = armed_r;
  assign INTERRUPT_INIT_STATE = init_r;
  assign INTERRUPT_TRANSITION = trans_r;
  assign ANY_TRANSITION       = any_r;

endmodule

// File: tb/tb_interrupt_monitor_multi.sv
// Directed self-checking bench for interrupt_monitor_multi
// (N_CH=4, SYNC_STAGES=3, CNT_W=2 so saturation is reachable).
module tb_interrupt_monitor_multi;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       STOP;
  logic [1:0] EDGE_SEL;
  logic [3:0] CH_MASK;
  logic [3:0] INTERRUPT_BAR;
  logic       BUSY;
  logic       ARMED;
  logic [3:0] INTERRUPT_INIT_STATE;
  logic [3:0] INTERRUPT_TRANSITION;
  logic       ANY_TRANSITION;
  logic [7:0] TRANSITION_COUNT;

  int checks = 0;
  int errors = 0;

  interrupt_monitor_multi #(.N_CH(4), .SYNC_STAGES(3), .CNT_W(2)) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .START                (START),
    .STOP                 (STOP),
    .EDGE_SEL             (EDGE_SEL),
    .CH_MASK              (CH_MASK),
    .INTERRUPT_BAR        (INTERRUPT_BAR),
    .BUSY                 (BUSY),
    .ARMED                (ARMED),
    .INTERRUPT_INIT_STATE (INTERRUPT_INIT_STATE),
    .INTERRUPT_TRANSITION (INTERRUPT_TRANSITION),
    .ANY_TRANSITION       (ANY_TRANSITION),
    .TRANSITION_COUNT     (TRANSITION_COUNT)
  );

  always #5 CLK = ~CLK;

  // Advance one clock and settle just after the active edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected count: zero when the counter feature is compiled out.
  function automatic logic [7:0] cexp(input logic [7:0] v);
`ifdef INTERRUPT_MONITOR_COUNT_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction

  initial begin
    RST = 1'b1; START = 1'b0; STOP = 1'b0;
    EDGE_SEL = 2'b00; CH_MASK = 4'b1111; INTERRUPT_BAR = 4'b1111;
    tick(2);
    chk("rst_busy",  {31'd0, BUSY}, 32'd0);
    chk("rst_armed", {31'd0, ARMED}, 32'd0);
    chk("rst_init",  {28'd0, INTERRUPT_INIT_STATE}, 32'd0);
    chk("rst_trans", {28'd0, INTERRUPT_TRANSITION}, 32'd0);
    chk("rst_any",   {31'd0, ANY_TRANSITION}, 32'd0);
    chk("rst_count", {24'd0, TRANSITION_COUNT}, 32'd0);
    RST = 1'b0;
    tick(1);

    // Falling mode, ch2 drops 10 cycles after arming.
    START = 1'b1; tick(1);
    chk("t1_busy_latch", {31'd0, BUSY}, 32'd1);
    START = 1'b0; tick(1);
    chk("t1_busy_reset", {31'd0, BUSY}, 32'd1);
    tick(1);
    chk("t1_armed", {31'd0, ARMED}, 32'd1);
    chk("t1_busy_off", {31'd0, BUSY}, 32'd0);
    chk("t1_init", {28'd0, INTERRUPT_INIT_STATE}, 32'hF);
    tick(7);
    INTERRUPT_BAR = 4'b1011;
    tick(4);
    chk("t1_latency_early", {28'd0, INTERRUPT_TRANSITION}, 32'h0);
    tick(1);
    chk("t1_trans", {28'd0, INTERRUPT_TRANSITION}, 32'h4);
    chk("t1_any", {31'd0, ANY_TRANSITION}, 32'd1);
    chk("t1_count", {24'd0, TRANSITION_COUNT}, {24'd0, cexp(8'h10)});

    // Rising mode, ch0 pulses low then high.
    INTERRUPT_BAR = 4'b1111; tick(6);
    EDGE_SEL = 2'b01;
    START = 1'b1; tick(1); START = 1'b0; tick(2);
    chk("t2_armed", {31'd0, ARMED}, 32'd1);
    chk("t2_cleared", {28'd0, INTERRUPT_TRANSITION}, 32'h0);
    chk("t2_cnt_cleared", {24'd0, TRANSITION_COUNT}, 32'h0);
    INTERRUPT_BAR = 4'b1110; tick(6);
    chk("t2_fall_ignored", {28'd0, INTERRUPT_TRANSITION}, 32'h0);
    INTERRUPT_BAR = 4'b1111; tick(4);
    chk("t2_latency_early", {28'd0, INTERRUPT_TRANSITION}, 32'h0);
    tick(1);
    chk("t2_rise", {28'd0, INTERRUPT_TRANSITION}, 32'h1);
    chk("t2_count", {24'd0, TRANSITION_COUNT}, {24'd0, cexp(8'h01)});

    // Both-edge mode, five toggles on ch1 saturate a 2-bit counter.
    EDGE_SEL = 2'b10;
    START = 1'b1; tick(1); START = 1'b0; tick(2);
    chk("t3_cleared", {28'd0, INTERRUPT_TRANSITION}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      INTERRUPT_BAR[1] = ~INTERRUPT_BAR[1];
      tick(5);
    end
    chk("t3_trans", {28'd0, INTERRUPT_TRANSITION}, 32'h2);
    chk("t3_count_sat", {24'd0, TRANSITION_COUNT}, {24'd0, cexp(8'h0C)});
    STOP = 1'b1; tick(1); STOP = 1'b0; tick(1);
    chk("t3_stopped", {31'd0, ARMED}, 32'd0);
    chk("t3_hold_trans", {28'd0, INTERRUPT_TRANSITION}, 32'h2);
    chk("t3_hold_any", {31'd0, ANY_TRANSITION}, 32'd1);
    INTERRUPT_BAR = 4'b0111; tick(6);
    chk("t3_idle_no_detect", {28'd0, INTERRUPT_TRANSITION}, 32'h2);
    chk("t3_idle_count", {24'd0, TRANSITION_COUNT}, {24'd0, cexp(8'h0C)});

    // Masked ch0, config changes while armed must not take effect.
    EDGE_SEL = 2'b00; CH_MASK = 4'b1110;
    START = 1'b1; tick(1); START = 1'b0; tick(2);
    chk("t4_init", {28'd0, INTERRUPT_INIT_STATE}, 32'h7);
    CH_MASK = 4'b1111; EDGE_SEL = 2'b01;
    INTERRUPT_BAR = 4'b0100; tick(6);
    chk("t4_masked", {28'd0, INTERRUPT_TRANSITION}, 32'h2);
    chk("t4_count", {24'd0, TRANSITION_COUNT}, {24'd0, cexp(8'h04)});

    // START and STOP together in ARMED re-arms; held START ignored while busy.
    START = 1'b1; STOP = 1'b1; tick(1);
    chk("t5_busy1", {31'd0, BUSY}, 32'd1);
    chk("t5_not_armed", {31'd0, ARMED}, 32'd0);
    tick(1);
    chk("t5_busy2", {31'd0, BUSY}, 32'd1);
    START = 1'b0; STOP = 1'b0; tick(1);
    chk("t5_armed", {31'd0, ARMED}, 32'd1);
    chk("t5_busy_off", {31'd0, BUSY}, 32'd0);
    chk("t5_cleared", {28'd0, INTERRUPT_TRANSITION}, 32'h0);
    chk("t5_any_cleared", {31'd0, ANY_TRANSITION}, 32'd0);
    chk("t5_init_masked_ch", {28'd0, INTERRUPT_INIT_STATE}, 32'h4);

    // Reset while in LATCHINITSTATE, then a normal arm.
    INTERRUPT_BAR = 4'b0101; tick(6);
    chk("t6_pre_trans", {28'd0, INTERRUPT_TRANSITION}, 32'h1);
    START = 1'b1; tick(1);
    chk("t6_busy", {31'd0, BUSY}, 32'd1);
    RST = 1'b1; START = 1'b0; tick(1);
    chk("t6_busy", {31'd0, BUSY}, 32'd0);
    chk("t6_armed", {31'd0, ARMED}, 32'd0);
    chk("t6_init", {28'd0, INTERRUPT_INIT_STATE}, 32'h0);
    chk("t6_trans", {28'd0, INTERRUPT_TRANSITION}, 32'h0);
    chk("t6_any", {31'd0, ANY_TRANSITION}, 32'd0);
    chk("t6_count", {24'd0, TRANSITION_COUNT}, 32'h0);
    RST = 1'b0; tick(6);
    STOP = 1'b1; tick(1); STOP = 1'b0; tick(1);
    chk("t6_stop_idle", {31'd0, ARMED | BUSY}, 32'd0);
    START = 1'b1; tick(1); START = 1'b0; tick(2);
    chk("t6_rearm", {31'd0, ARMED}, 32'd1);
    chk("t6_rearm_init", {28'd0, INTERRUPT_INIT_STATE}, 32'h5);
    INTERRUPT_BAR = 4'b0111; tick(6);
    chk("t6_rise", {28'd0, INTERRUPT_TRANSITION}, 32'h2);
    chk("t6_any_set", {31'd0, ANY_TRANSITION}, 32'd1);
    chk("t6_count_after", {24'd0, TRANSITION_COUNT}, {24'd0, cexp(8'h04)});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_monitor_multi.md
INTERRUPT_MONITOR_MULTI -- requirements
Module: interrupt_monitor_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of monitored interrupt lines (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 3, synchronizer depth per line (2..4).
REQ-003 SHALL have parameter CNT_W, default 8, per-channel transition counter width (1..16).
REQ-004 SHALL have port CLK  in  1  system clock; the block uses one clock only.
REQ-005 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port START  in  1  pulse that begins an arm sequence.
REQ-007 SHALL have port STOP  in  1  pulse that disarms detection.
REQ-008 SHALL have port EDGE_SEL  in  2  edge mode: 00 falling, 01 rising, 10 both, 11 treated as falling.
REQ-009 SHALL have port CH_MASK  in  N_CH  1 = channel enabled for detection.
REQ-010 SHALL have port INTERRUPT_BAR  in  N_CH  asynchronous active-low interrupt lines.
REQ-011 SHALL have port BUSY  out  1  high during LATCHINITSTATE and RESETTRANSITIONREG.
REQ-012 SHALL have port ARMED  out  1  high in state ARMED.
REQ-013 SHALL have port INTERRUPT_INIT_STATE  out  N_CH  synchronized line level captured at arm.
REQ-014 SHALL have port INTERRUPT_TRANSITION  out  N_CH  sticky per-channel edge flags.
REQ-015 SHALL have port ANY_TRANSITION  out  1  OR of INTERRUPT_TRANSITION.
REQ-016 SHALL have port TRANSITION_COUNT  out  N_CH*CNT_W  per-channel counts, channel i at bits [i*CNT_W +: CNT_W].

Function
REQ-017 SHALL implement states IDLE, LATCHINITSTATE, RESETTRANSITIONREG, ARMED.
REQ-018 SHALL go IDLE->LATCHINITSTATE on START; LATCHINITSTATE->RESETTRANSITIONREG->ARMED unconditionally, one cycle each.
REQ-019 SHALL go ARMED->LATCHINITSTATE on START (re-arm), ARMED->IDLE on STOP; START wins over simultaneous STOP.
REQ-020 SHALL ignore START and STOP while BUSY; STOP in IDLE has no effect.
REQ-021 SHALL latch EDGE_SEL and CH_MASK in LATCHINITSTATE; changes at other times take effect only at next arm.
REQ-022 SHALL synchronize each line through SYNC_STAGES flops plus one history flop, all resetting to 1.
REQ-023 SHALL capture the last synchronizer stage of every channel (masked or not) into INTERRUPT_INIT_STATE in LATCHINITSTATE.
REQ-024 SHALL clear all INTERRUPT_TRANSITION bits and counters in RESETTRANSITIONREG; edges arriving that cycle are discarded.
REQ-025 SHALL in ARMED set INTERRUPT_TRANSITION[i] when channel i is enabled and the last stage versus history flop shows the selected edge.
REQ-026 SHALL make flags sticky until next RESETTRANSITIONREG; flags and counts hold through STOP and IDLE.
REQ-027 SHALL register flags so a pin edge sampled at clock edge k appears on INTERRUPT_TRANSITION after edge k+SYNC_STAGES+1.
REQ-028 SHALL in both-edge mode detect rising and falling edges alike.
REQ-029 SHALL increment TRANSITION_COUNT[i] once per qualified edge, saturating at 2^CNT_W-1 (no wrap).
REQ-030 SHALL keep ANY_TRANSITION registered-aligned with INTERRUPT_TRANSITION (combinational OR permitted).

Reset
REQ-031 SHALL on RST: state IDLE, BUSY=0, ARMED=0, INIT_STATE=0, TRANSITION=0, counts=0, synchronizers=all ones, latched EDGE_SEL=00, CH_MASK=0.
REQ-032 SHALL give RST priority over START/STOP; reset mid-sequence returns to IDLE with all above values next cycle.

Configuration
REQ-033 SHALL compile counters only when macro INTERRUPT_MONITOR_COUNT_EN is defined; without it TRANSITION_COUNT is tied to 0 and no counter flops exist, flag behaviour unchanged.

Structure
REQ-034 SHALL place state encoding (2-bit) and EDGE_SEL code constants in package interrupt_monitor_pkg.
REQ-035 SHALL instantiate per channel sub-module interrupt_sync_edge (synchronizer, history flop, rise/fall outputs) via generate.

Verification
REQ-036 SHALL cover: N_CH=4, lines high, START, ch2 low 10 cycles later, mode 00 -> TRANSITION=0100, ANY=1, count[2]=1.
REQ-037 SHALL cover: mode 01, ch0 pulses low then high -> only rising edge flagged, TRANSITION[0]=1 after SYNC_STAGES+1 cycles from rise.
REQ-038 SHALL cover: mode 10, CNT_W=2, 5 toggles on ch1 -> count[1]=3 (saturated), flag stays 1 after STOP.
REQ-039 SHALL cover: CH_MASK=1110, ch0 falls -> TRANSITION[0]=0, INIT_STATE[0] still captured correctly.
REQ-040 SHALL cover: START and STOP same cycle in ARMED -> re-arm, BUSY=1 two cycles, flags cleared.
REQ-041 SHALL cover: RST asserted in LATCHINITSTATE -> next cycle IDLE, all outputs 0, later START arms normally.
